// File: rtl/spi_seq_ctrl_if.sv
// Host-side and SPI-master-side signal bundle for spi_seq_ctrl.
// slave = the sequencer, master = host plus SPI master.
interface spi_seq_ctrl_if #(
    parameter int AW = 4
);
    // Handshakes: a start is taken on a clock edge where i_start=1, o_ready=1 and i_len!=0.
    // A write is taken on any edge with i_wr_en=1 and o_ready=1.
    // Toward the SPI master, o_spi_tx_rx is a request held high until i_spi_busy=1 is seen.
    // The byte is complete on the first edge after that at which i_spi_busy=0.
    // o_rx_valid and o_done are single-cycle pulses with no back-pressure.
    logic          i_wr_en;
    logic [7:0]    i_wr_data;
    logic          i_start;
    logic [AW:0]   i_len;
    logic          i_abort;
    logic          o_ready;
    logic          o_rx_valid;
    logic [7:0]    o_rx_data;
    logic [AW-1:0] o_rx_index;
    logic          o_done;
    logic          o_err;
    logic          o_spi_tx_rx;
    logic [7:0]    o_spi_tx_data;
    logic          i_spi_busy;
    logic [7:0]    i_spi_rx_data;

    modport slave (
        input  i_wr_en, i_wr_data, i_start, i_len, i_abort, i_spi_busy, i_spi_rx_data,
        output o_ready, o_rx_valid, o_rx_data, o_rx_index, o_done, o_err,
        output o_spi_tx_rx, o_spi_tx_data
    );

    modport master (
        output i_wr_en, i_wr_data, i_start, i_len, i_abort, i_spi_busy, i_spi_rx_data,
        input  o_ready, o_rx_valid, o_rx_data, o_rx_index, o_done, o_err,
        input  o_spi_tx_rx, o_spi_tx_data
    );
endinterface

// File: rtl/spi_seq_ctrl.sv
// Multi-byte SPI transaction sequencer: buffers TX bytes, feeds the SPI master byte by byte and
// returns indexed RX bytes. Define SPI_SEQ_TIMEOUT_EN to enable the REQ/WAIT_LO watchdog.
module spi_seq_ctrl #(
    parameter int BUF_DEPTH      = 16,
    parameter int AW             = 4,
    parameter int GAP_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    spi_seq_ctrl_if.slave bus,
    output logic [2:0]    dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT_LO = 3'd2,
        S_CAPTURE = 3'd3,
        S_GAP     = 3'd4,
        S_DONE    = 3'd5,
        S_DRAIN   = 3'd6
    } state_t;

    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(BUF_DEPTH);

    state_t        state, state_n;
    logic [AW-1:0] wr_ptr, wr_ptr_n;
    logic [AW-1:0] idx, idx_n;
    logic [AW:0]   len, len_n;
    logic [CW-1:0] cnt;
    logic          cnt_en;
    logic          timeout;
    logic          abort_hit;
    logic          wr_fire;
    logic [7:0]    tx_next;
    logic [7:0]    tx_buf [BUF_DEPTH];

    logic          rx_valid_q;
    logic [7:0]    rx_data_q;
    logic [AW-1:0] rx_index_q;
    logic          done_q;
    logic          tx_rx_q;
    logic [7:0]    tx_data_q;

    assign wr_fire   = (state == S_IDLE) && bus.i_wr_en;
    assign abort_hit = (state != S_IDLE) && bus.i_abort;

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        idx_n    = idx;
        len_n    = len;
        cnt_en   = 1'b0;
        timeout  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.i_wr_en) wr_ptr_n = wr_ptr + 1'b1;
                if (bus.i_start && (bus.i_len != '0)) begin
                    state_n = S_REQ;
                    idx_n   = '0;
                    len_n   = (bus.i_len > LEN_MAX) ? LEN_MAX : bus.i_len;
                end
            end
            S_REQ: begin
                if (bus.i_spi_busy) state_n = S_WAIT_LO;
`ifdef SPI_SEQ_TIMEOUT_EN
                cnt_en  = 1'b1;
                timeout = !bus.i_spi_busy && !abort_hit && (cnt == CW'(TIMEOUT_CYCLES - 1));
`endif
            end
            S_WAIT_LO: begin
                if (!bus.i_spi_busy) state_n = S_CAPTURE;
`ifdef SPI_SEQ_TIMEOUT_EN
                cnt_en  = 1'b1;
                timeout = bus.i_spi_busy && !abort_hit && (cnt == CW'(TIMEOUT_CYCLES - 1));
`endif
            end
            S_CAPTURE: begin
                if ({1'b0, idx} == (len - 1'b1)) begin
                    state_n = S_DONE;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                cnt_en = 1'b1;
                if (cnt == CW'(GAP_CYCLES - 1)) state_n = S_REQ;
            end
            S_DONE: begin
                wr_ptr_n = '0;
                state_n  = S_IDLE;
            end
            S_DRAIN: begin
                if (!bus.i_spi_busy) begin
                    wr_ptr_n = '0;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (timeout) begin
            state_n  = S_IDLE;
            wr_ptr_n = '0;
        end
        // Abort wins over every other exit; a CAPTURE pulse already on the outputs still stands.
        if (abort_hit) state_n = S_DRAIN;
    end

    // Same-cycle write+start must present the freshly written byte when it lands at index 0.
    assign tx_next = (wr_fire && (wr_ptr == idx_n)) ? bus.i_wr_data : tx_buf[idx_n];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            idx        <= '0;
            len        <= '0;
            cnt        <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_index_q <= '0;
            done_q     <= 1'b0;
            tx_rx_q    <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr_n;
            idx        <= idx_n;
            len        <= len_n;
            cnt        <= (cnt_en && (state_n == state)) ? cnt + 1'b1 : '0;
            rx_valid_q <= (state_n == S_CAPTURE);
            done_q     <= (state_n == S_DONE);
            tx_rx_q    <= (state_n == S_REQ);
            if (state_n == S_CAPTURE) begin
                rx_data_q  <= bus.i_spi_rx_data;
                rx_index_q <= idx;
            end
            if ((state_n == S_REQ) && (state != S_REQ)) tx_data_q <= tx_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && wr_fire) tx_buf[wr_ptr] <= bus.i_wr_data;
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    logic err_q;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if ((state == S_IDLE) && (state_n == S_REQ)) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end
    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

    assign bus.o_ready       = (state == S_IDLE);
    assign bus.o_rx_valid    = rx_valid_q;
    assign bus.o_rx_data     = rx_data_q;
    assign bus.o_rx_index    = rx_index_q;
    assign bus.o_done        = done_q;
    assign bus.o_spi_tx_rx   = tx_rx_q;
    assign bus.o_spi_tx_data = tx_data_q;
    assign dbg_state         = state;
endmodule

// File: tb/tb_spi_seq_ctrl.sv
// Bench for spi_seq_ctrl: random host traffic and a loopback SPI master model, scored against a
// shadow-buffer model of what each transaction must return.
module tb_spi_seq_ctrl;
    localparam int BUF_DEPTH = 16;
    localparam int AW        = 4;
    localparam int GAP       = 64;
    localparam int TO        = 1024;
    localparam int W         = AW + 8;

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;
    logic       master_en;
    logic       mst_busy;
    logic       man_busy;
    logic [7:0] mst_rx;

    spi_seq_ctrl_if #(.AW(AW)) bus ();

    spi_seq_ctrl #(
        .BUF_DEPTH(BUF_DEPTH),
        .AW(AW),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    assign bus.i_spi_busy    = master_en ? mst_busy : man_busy;
    assign bus.i_spi_rx_data = mst_rx;

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #(800_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   shadow [BUF_DEPTH];
    int sh_ptr   = 0;
    int exp_n    = 0;
    int rx_cnt   = 0;
    int done_cnt = 0;
    int req_cnt  = 0;
    int extra_rx = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    logic         prev_txrx;
    logic         track;
    int           since_rx;
    logic [W-1:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_txrx = 1'b0;
            track     = 1'b0;
        end else begin
            if (bus.o_rx_valid) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    extra_rx++;
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte", {bus.o_rx_index, bus.o_rx_data}, e);
                end
            end
            if (bus.o_done) done_cnt++;
            if (bus.o_spi_tx_rx && !prev_txrx) begin
                req_cnt++;
                if (track) check("gap_len", since_rx, GAP);
                track = 1'b0;
            end else if (track && !bus.o_spi_tx_rx) begin
                since_rx++;
            end
            if (bus.o_rx_valid) begin
                track    = 1'b1;
                since_rx = 0;
            end
            if (bus.o_ready) track = 1'b0;
            prev_txrx = bus.o_spi_tx_rx;
        end
    end

    // ---------------- SPI master model: loopback of ~tx ----------------
    initial begin : spi_master
        logic [7:0] lat_tx;
        int         nb;
        mst_busy = 1'b0;
        mst_rx   = 8'h00;
        forever begin
            @(negedge clk);
            if (master_en && rst_n && bus.o_spi_tx_rx && !mst_busy) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                lat_tx   = bus.o_spi_tx_data;
                mst_busy = 1'b1;
                nb       = $urandom_range(1, 6);
                for (int j = 0; j < nb; j++) begin
                    @(negedge clk);
                    check("tx_stable", bus.o_spi_tx_data, lat_tx);
                end
                mst_rx   = ~lat_tx;
                mst_busy = 1'b0;
            end
        end
    end

    // ---------------- driver tasks (enter and leave #1 after a posedge) ----------------
    task automatic host_write(input logic [7:0] b, input bit in_idle);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = b;
        @(posedge clk); #1;
        bus.i_wr_en = 1'b0;
        if (in_idle) begin
            shadow[sh_ptr] = b;
            sh_ptr = (sh_ptr + 1) % BUF_DEPTH;
        end
    endtask

    task automatic host_start(input int len, input bit with_wr, input logic [7:0] b);
        int eff;
        if (with_wr) begin
            shadow[sh_ptr] = b;
            sh_ptr = (sh_ptr + 1) % BUF_DEPTH;
        end
        eff = (len > BUF_DEPTH) ? BUF_DEPTH : len;
        for (int i = 0; i < eff; i++) exp_q.push_back({AW'(i), ~shadow[i]});
        exp_n = eff;
        bus.i_start   = 1'b1;
        bus.i_len     = (AW+1)'(len);
        bus.i_wr_en   = with_wr;
        bus.i_wr_data = b;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_wr_en = 1'b0;
    endtask

    task automatic wait_ready(input int max_cyc);
        int n;
        n = 0;
        while (!bus.o_ready && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("ready_within_budget", bus.o_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic finish_txn(input int rx0, input int d0, input int q0, input int eff);
        wait_ready(4000);
        check("rx_count", rx_cnt - rx0, eff);
        check("req_count", req_cnt - q0, eff);
        check("done_count", done_cnt - d0, 1);
        check("exp_drained", exp_q.size(), 0);
        check("extra_rx", extra_rx, 0);
        sh_ptr = 0;
    endtask

    task automatic txn(input int len, input bit with_wr, input logic [7:0] b);
        int rx0, d0, q0;
        rx0 = rx_cnt;
        d0  = done_cnt;
        q0  = req_cnt;
        host_start(len, with_wr, b);
        finish_txn(rx0, d0, q0, exp_n);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rx0, d0, q0, n, n_hi, nw, ln;
        bus.i_wr_en   = 1'b0;
        bus.i_wr_data = 8'h00;
        bus.i_start   = 1'b0;
        bus.i_len     = '0;
        bus.i_abort   = 1'b0;
        master_en     = 1'b1;
        man_busy      = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", bus.o_ready, 1);
        check("rst_tx_rx", bus.o_spi_tx_rx, 0);
        check("rst_tx_data", bus.o_spi_tx_data, 0);
        check("rst_rx_valid", bus.o_rx_valid, 0);
        check("rst_rx_data", bus.o_rx_data, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_err", bus.o_err, 0);
        @(posedge clk); #1;

        // Directed three-byte transfer: A5,3C,FF -> 5A,C3,00
        host_write(8'hA5, 1);
        host_write(8'h3C, 1);
        host_write(8'hFF, 1);
        txn(3, 0, 8'h00);

        // Zero length start is ignored
        d0 = done_cnt;
        q0 = req_cnt;
        host_start(0, 0, 8'h00);
        repeat (20) @(negedge clk);
        check("len0_ready", bus.o_ready, 1);
        check("len0_req", req_cnt - q0, 0);
        check("len0_done", done_cnt - d0, 0);
        @(posedge clk); #1;

        // Fill the buffer, then over-long length clamps to BUF_DEPTH
        for (int i = 0; i < BUF_DEPTH; i++) host_write(8'($urandom_range(0, 255)), 1);
        txn(20, 0, 8'h00);

        // Same-cycle write and start: new byte at index 0, then at index 1
        txn(1, 1, 8'h3E);
        host_write(8'($urandom_range(0, 255)), 1);
        txn(3, 1, 8'($urandom_range(0, 255)));

        // Writes during a transaction are dropped
        rx0 = rx_cnt;
        d0  = done_cnt;
        q0  = req_cnt;
        host_start(4, 0, 8'h00);
        repeat (30) @(posedge clk); #1;
        host_write(8'h11, 0);
        host_write(8'h22, 0);
        finish_txn(rx0, d0, q0, exp_n);
        txn(4, 0, 8'h00);

        // Random traffic
        for (int it = 0; it < 6; it++) begin
            nw = $urandom_range(0, BUF_DEPTH);
            for (int i = 0; i < nw; i++) host_write(8'($urandom_range(0, 255)), 1);
            ln = $urandom_range(1, 20);
            txn(ln, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        // Abort in WAIT_LO with busy held ~100 more cycles
        master_en = 1'b0;
        man_busy  = 1'b0;
        rx0 = rx_cnt;
        d0  = done_cnt;
        q0  = req_cnt;
        host_start(4, 0, 8'h00);
        check("abort_req_high", bus.o_spi_tx_rx, 1);
        man_busy = 1'b1;
        repeat (3) @(posedge clk); #1;
        bus.i_abort = 1'b1;
        @(posedge clk); #1;
        bus.i_abort = 1'b0;
        exp_q.delete();
        sh_ptr = 0;
        repeat (95) @(posedge clk); #1;
        check("drain_hold_ready", bus.o_ready, 0);
        check("drain_hold_tx_rx", bus.o_spi_tx_rx, 0);
        man_busy = 1'b0;
        @(negedge clk);
        check("drain_ready_early", bus.o_ready, 0);
        @(negedge clk);
        check("drain_ready", bus.o_ready, 1);
        check("abort_rx", rx_cnt - rx0, 0);
        check("abort_done", done_cnt - d0, 0);
        check("abort_req", req_cnt - q0, 1);
        @(posedge clk); #1;

`ifdef SPI_SEQ_TIMEOUT_EN
        // Busy never asserts: watchdog returns to IDLE with o_err set
        rx0 = rx_cnt;
        d0  = done_cnt;
        host_start(2, 0, 8'h00);
        n    = 0;
        n_hi = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (bus.o_ready) break;
            if (bus.o_spi_tx_rx) n_hi++;
            n++;
        end
        check("to_req_cycles", n_hi, TO);
        check("to_ready", bus.o_ready, 1);
        check("to_err", bus.o_err, 1);
        check("to_done", done_cnt - d0, 0);
        check("to_rx", rx_cnt - rx0, 0);
        exp_q.delete();
        sh_ptr = 0;
        repeat (5) @(posedge clk); #1;
        check("to_err_sticky", bus.o_err, 1);
        master_en = 1'b1;
        txn(2, 0, 8'h00);
        check("to_err_cleared", bus.o_err, 0);
`else
        // Busy never asserts: without the watchdog the request is held
        d0 = done_cnt;
        host_start(2, 0, 8'h00);
        repeat (300) @(negedge clk);
        check("hold_tx_rx", bus.o_spi_tx_rx, 1);
        check("hold_ready", bus.o_ready, 0);
        check("hold_err", bus.o_err, 0);
        @(posedge clk); #1;
        bus.i_abort = 1'b1;
        @(posedge clk); #1;
        bus.i_abort = 1'b0;
        exp_q.delete();
        sh_ptr = 0;
        wait_ready(10);
        check("hold_done", done_cnt - d0, 0);
        master_en = 1'b1;
`endif

        // Reset for one edge during GAP
        rx0 = rx_cnt;
        host_start(3, 0, 8'h00);
        n = 0;
        while (rx_cnt == rx0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("gap_first_rx", rx_cnt - rx0, 1);
        repeat (5) @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        sh_ptr = 0;
        @(negedge clk);
        check("gaprst_ready", bus.o_ready, 1);
        check("gaprst_tx_rx", bus.o_spi_tx_rx, 0);
        check("gaprst_rx_valid", bus.o_rx_valid, 0);
        check("gaprst_done", bus.o_done, 0);
        q0  = req_cnt;
        rx0 = rx_cnt;
        repeat (100) @(negedge clk);
        check("gaprst_no_req", req_cnt - q0, 0);
        check("gaprst_no_rx", rx_cnt - rx0, 0);
        check("final_extra_rx", extra_rx, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
